// File: rtl/inst_issue_queue_pkg.sv
// Shared types and constants for the IF->ID instruction issue queue and its decoder.
package inst_issue_queue_pkg;

  localparam int INST_ENTRY_WD = 64;

  // Entry layout: PC in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

  typedef enum logic {
    SingleIssue = 1'b0,
    DualIssue   = 1'b1
  } issue_mode_e;

  function automatic int pop_cnt_wd(input int issue_w);
    return (issue_w < 1) ? 1 : $clog2(issue_w + 1);
  endfunction

endpackage

// File: rtl/inst_issue_compact.sv
// Packs the valid fetch slots of one bundle into consecutive entries, slot order kept,
// and reports how many entries were produced.
module inst_issue_compact
  import inst_issue_queue_pkg::*;
#(
  parameter int FETCH_W = 2
) (
  input  logic [FETCH_W*32-1:0]            push_inst_i,
  input  logic [FETCH_W*32-1:0]            push_pc_i,
  input  logic [FETCH_W-1:0]               push_valid_i,
  output logic [FETCH_W*INST_ENTRY_WD-1:0] wr_vec_o,
  output logic [$clog2(FETCH_W+1)-1:0]     wr_cnt_o
);

  localparam int NW = $clog2(FETCH_W + 1);

  int unsigned pos;

  always_comb begin
    wr_vec_o = '0;
    pos      = 0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (push_valid_i[i]) begin
        wr_vec_o[pos*INST_ENTRY_WD +: INST_ENTRY_WD] = {push_pc_i[i*32 +: 32], push_inst_i[i*32 +: 32]};
        pos = pos + 1;
      end
    end
    wr_cnt_o = pos[NW-1:0];
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Circular instruction buffer between IF and the dual-issue decoder, with flush/delay-slot
// retention and an almost-full request. Define INSTQ_PERF_EN to add saturating perf counters.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          keep_ds_i,
  input  logic [FETCH_W*32-1:0]         push_inst_i,
  input  logic [FETCH_W*32-1:0]         push_pc_i,
  input  logic [FETCH_W-1:0]            push_valid_i,
  input  logic [pop_cnt_wd(ISSUE_W)-1:0] pop_cnt_i,
  output logic [ISSUE_W*32-1:0]         issue_inst_o,
  output logic [ISSUE_W*32-1:0]         issue_pc_o,
  output logic [ISSUE_W-1:0]            issue_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          full_o,
  output logic                          overflow_o
`ifdef INSTQ_PERF_EN
  ,
  output logic [31:0]                   perf_full_cyc_o,
  output logic [31:0]                   perf_empty_cyc_o,
  output logic [31:0]                   perf_drop_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(FETCH_W + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH = CW'(2 * FETCH_W);

  inst_entry_t mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, ovf_q, ovf_d, ds_wait_q, ds_wait_d;
  logic [FETCH_W*INST_ENTRY_WD-1:0] wr_vec;
  logic [NW-1:0] wr_cnt;
  logic [CW-1:0] pop_req, popped, free_slots, push_n;
  logic [FETCH_W-1:0] we;
  logic          drop;

  inst_issue_compact #(.FETCH_W(FETCH_W)) u_compact (
    .push_inst_i  (push_inst_i),
    .push_pc_i    (push_pc_i),
    .push_valid_i (push_valid_i),
    .wr_vec_o     (wr_vec),
    .wr_cnt_o     (wr_cnt)
  );

  // While waiting for the delay slot only the lowest valid slot (compacted slot 0) is kept.
  always_comb begin
    pop_req    = CW'(pop_cnt_i);
    popped     = (pop_req > count_q) ? count_q : pop_req;
    free_slots = DEPTH_C - count_q + popped;
    if (ds_wait_q) push_n = (wr_cnt != '0) ? CW'(1) : '0;
    else           push_n = CW'(wr_cnt);
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ds_wait_d = ds_wait_q;
    we        = '0;
    drop      = 1'b0;
    if (flush_i) begin
      head_d = head_q + PW'(popped);
      if (keep_ds_i && (count_q > popped)) begin
        tail_d    = head_d + PW'(1);
        count_d   = CW'(1);
        ds_wait_d = 1'b0;
      end else begin
        tail_d    = head_d;
        count_d   = '0;
        ds_wait_d = keep_ds_i;
      end
    end else if (!stall_i) begin
      head_d  = head_q + PW'(popped);
      count_d = count_q - popped;
      if (push_n != '0) begin
        if (push_n <= free_slots) begin
          for (int k = 0; k < FETCH_W; k++) we[k] = (CW'(k) < push_n);
          tail_d    = tail_q + PW'(push_n);
          count_d   = count_d + push_n;
          ds_wait_d = 1'b0;
        end else begin
          drop = 1'b1;
        end
      end
    end
    ovf_d  = ovf_q | drop;
    full_d = (DEPTH_C - count_d) < FULL_TH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ds_wait_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      ds_wait_q <= ds_wait_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (we[k]) mem_q[tail_q + PW'(k)] <= inst_entry_t'(wr_vec[k*INST_ENTRY_WD +: INST_ENTRY_WD]);
    end
  end

  always_comb begin
    issue_inst_o  = '0;
    issue_pc_o    = '0;
    issue_valid_o = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (count_q > CW'(k)) begin
        issue_valid_o[k]       = 1'b1;
        issue_inst_o[k*32 +: 32] = mem_q[head_q + PW'(k)].inst;
        issue_pc_o[k*32 +: 32]   = mem_q[head_q + PW'(k)].pc;
      end
    end
  end

  assign count_o    = count_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

  pop_in_range: assert property (@(posedge clk) disable iff (!rst) (stall_i || pop_req <= count_q));

`ifdef INSTQ_PERF_EN
  logic [31:0] perf_full_q, perf_empty_q, perf_drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (full_q && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
      if ((count_q == '0) && !stall_i && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
      if (drop && (perf_drop_q != '1)) perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_full_cyc_o  = perf_full_q;
  assign perf_empty_cyc_o = perf_empty_q;
  assign perf_drop_o      = perf_drop_q;
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue (DEPTH=16, FETCH_W=2, ISSUE_W=2).
module tb_inst_issue_queue;
  import inst_issue_queue_pkg::*;

  localparam int DEPTH   = 16;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, keep_ds = 1'b0;
  logic [63:0] push_inst = '0, push_pc = '0;
  logic [1:0]  push_valid = '0;
  logic [1:0]  pop_cnt = '0;
  logic [63:0] issue_inst, issue_pc;
  logic [1:0]  issue_valid;
  logic [4:0]  count;
  logic        full, ovf;
`ifdef INSTQ_PERF_EN
  logic [31:0] perf_full, perf_empty, perf_drop;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .keep_ds_i(keep_ds),
    .push_inst_i(push_inst), .push_pc_i(push_pc), .push_valid_i(push_valid), .pop_cnt_i(pop_cnt),
    .issue_inst_o(issue_inst), .issue_pc_o(issue_pc), .issue_valid_o(issue_valid),
    .count_o(count), .full_o(full), .overflow_o(ovf)
`ifdef INSTQ_PERF_EN
    , .perf_full_cyc_o(perf_full), .perf_empty_cyc_o(perf_empty), .perf_drop_o(perf_drop)
`endif
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] pop, input logic fl, input logic kd, input logic st);
    push_valid = v;
    push_pc    = {pc1, pc0};
    push_inst  = {inst_of(pc1), inst_of(pc0)};
    pop_cnt    = pop;
    flush      = fl;
    keep_ds    = kd;
    stall      = st;
    step();
    push_valid = '0;
    pop_cnt    = '0;
    flush      = 1'b0;
    keep_ds    = 1'b0;
    stall      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", issue_valid); end
    total++; if ({full, ovf} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {full, ovf}); end
    #2 rst = 1'b1;
    drive(2'b11, 32'h10, 32'h14, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 32'h18, 32'h1C, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 32'h20, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL pre_rst_count got=%0d exp=5", count); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    total++; if (issue_valid !== 2'b00) begin bad++; $display("FAIL mid_rst_valid got=%b exp=00", issue_valid); end
    total++; if (issue_pc !== 64'h0) begin bad++; $display("FAIL mid_rst_pc got=%h exp=0", issue_pc); end
    total++; if ({full, ovf} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags got=%b exp=00", {full, ovf}); end
    #1 rst = 1'b1;
    drive(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (issue_pc[31:0] !== 32'hBFC0_0000) begin bad++; $display("FAIL boot_pc0 got=%h exp=bfc00000", issue_pc[31:0]); end
    total++; if (issue_pc[63:32] !== 32'hBFC0_0004) begin bad++; $display("FAIL boot_pc1 got=%h exp=bfc00004", issue_pc[63:32]); end
    total++; if (issue_inst[31:0] !== inst_of(32'hBFC0_0000)) begin bad++; $display("FAIL boot_inst0 got=%h exp=%h", issue_inst[31:0], inst_of(32'hBFC0_0000)); end
    total++; if ({issue_valid, count} !== {2'b11, 5'd2}) begin bad++; $display("FAIL boot_state got=%b/%0d exp=11/2", issue_valid, count); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 2'd0, 1'b0, 1'b0, 1'b0);
      total++; if (count !== 5'(2*(i+1))) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, 2*(i+1)); end
      total++; if (full !== ((2*(i+1)) > 12)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (2*(i+1)) > 12); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf[%0d] got=%b exp=0", i, ovf); end
    end
    drive(2'b11, 32'h2000, 32'h2004, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d exp=16", count); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL drop_ovf got=%b exp=1", ovf); end
    total++; if (issue_pc !== {32'h1004, 32'h1000}) begin bad++; $display("FAIL drop_head got=%h exp=0000100400001000", issue_pc); end
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    total++; if ({count, full, ovf} !== {5'd14, 1'b1, 1'b1}) begin bad++; $display("FAIL sticky got=%0d/%b/%b exp=14/1/1", count, full, ovf); end
    total++; if (issue_pc[31:0] !== 32'h1008) begin bad++; $display("FAIL sticky_head got=%h exp=1008", issue_pc[31:0]); end
  endtask

  task automatic test_holes();
    do_reset();
    drive(2'b10, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL hole_count got=%0d exp=1", count); end
    total++; if (issue_valid !== 2'b01) begin bad++; $display("FAIL hole_valid got=%b exp=01", issue_valid); end
    total++; if (issue_pc !== {32'h0, 32'h104}) begin bad++; $display("FAIL hole_pc got=%h exp=0000000000000104", issue_pc); end
    total++; if (issue_inst[31:0] !== inst_of(32'h104)) begin bad++; $display("FAIL hole_inst got=%h exp=%h", issue_inst[31:0], inst_of(32'h104)); end
  endtask

  task automatic test_push_pop();
    do_reset();
    drive(2'b11, 32'h300, 32'h304, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 32'h308, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL pp_pre_count got=%0d exp=3", count); end
    drive(2'b11, 32'h30C, 32'h310, 2'd2, 1'b0, 1'b0, 1'b0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL pp_count got=%0d exp=3", count); end
    total++; if (issue_pc !== {32'h30C, 32'h308}) begin bad++; $display("FAIL pp_head got=%h exp=0000030c00000308", issue_pc); end
    drive(2'b11, 32'h400, 32'h404, 2'd1, 1'b0, 1'b0, 1'b1);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", count); end
    total++; if (issue_pc !== {32'h30C, 32'h308}) begin bad++; $display("FAIL stall_head got=%h exp=0000030c00000308", issue_pc); end
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0);
    total++; if ({count, issue_pc} !== {5'd2, 32'h310, 32'h30C}) begin bad++; $display("FAIL post_stall got=%0d/%h exp=2/000003100000030c", count, issue_pc); end
  endtask

  task automatic test_flush_ds();
    do_reset();
    drive(2'b11, 32'h400, 32'h404, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 32'h408, 32'h40C, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL ds_count got=%0d exp=1", count); end
    total++; if ({issue_valid, issue_pc[31:0]} !== {2'b01, 32'h404}) begin bad++; $display("FAIL ds_entry got=%b/%h exp=01/00000404", issue_valid, issue_pc[31:0]); end
    drive(2'b00, 32'h0, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0);
    total++; if ({count, issue_valid} !== {5'd0, 2'b00}) begin bad++; $display("FAIL ds_empty got=%0d/%b exp=0/00", count, issue_valid); end
    drive(2'b11, 32'h200, 32'h204, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if ({count, issue_pc[31:0]} !== {5'd1, 32'h200}) begin bad++; $display("FAIL ds_wait got=%0d/%h exp=1/00000200", count, issue_pc[31:0]); end
    drive(2'b11, 32'h208, 32'h20C, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if ({count, issue_pc[63:32]} !== {5'd3, 32'h208}) begin bad++; $display("FAIL ds_clear got=%0d/%h exp=3/00000208", count, issue_pc[63:32]); end
    drive(2'b11, 32'h600, 32'h604, 2'd1, 1'b1, 1'b0, 1'b0);
    total++; if ({count, issue_valid} !== {5'd0, 2'b00}) begin bad++; $display("FAIL flush got=%0d/%b exp=0/00", count, issue_valid); end
    drive(2'b11, 32'h700, 32'h704, 2'd0, 1'b0, 1'b0, 1'b0);
    total++; if ({count, issue_pc} !== {5'd2, 32'h704, 32'h700}) begin bad++; $display("FAIL post_flush got=%0d/%h exp=2/0000070400000700", count, issue_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] nxt;
    do_reset();
    exp_q.delete();
    drive(2'b11, 32'h500, 32'h504, 2'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h504);
    nxt = 32'h508;
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, nxt, nxt + 32'h4, 2'd2, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_back(nxt);
      exp_q.push_back(nxt + 32'h4);
      nxt = nxt + 32'h8;
      total++; if ({count, issue_valid, full} !== {5'd2, 2'b11, 1'b0}) begin bad++; $display("FAIL wrap_state[%0d] got=%0d/%b/%b exp=2/11/0", i, count, issue_valid, full); end
      total++; if (issue_pc !== {exp_q[1], exp_q[0]}) begin bad++; $display("FAIL wrap_pc[%0d] got=%h exp=%h%h", i, issue_pc, exp_q[1], exp_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_holes();
    test_push_pop();
    test_flush_ds();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
Name: inst_issue_queue

Overview:
- Parametrised circular instruction buffer between the IF stage and the dual-issue decoder in ID.
- Accepts up to FETCH_W {pc, inst} slots per cycle and presents up to ISSUE_W head entries to issue logic.
- Issue logic pops 0..ISSUE_W entries per cycle.
- Supports flush with optional delay-slot retention, and an almost-full stall request toward IF.

Parameters:
DEPTH, 16, entry count; power of two, >= 2*FETCH_W+ISSUE_W
FETCH_W, 2, fetch slots per cycle (1..4)
ISSUE_W, 2, issue slots per cycle (1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low
stall_i  in  1  freeze push and pop this cycle
flush_i  in  1  discard contents (redirect/exception)
keep_ds_i  in  1  qualifies flush_i: retain delay-slot instruction
push_inst_i  in  FETCH_W*32  fetched instructions, slot 0 lowest address
push_pc_i  in  FETCH_W*32  PCs of fetched slots
push_valid_i  in  FETCH_W  per-slot valid; holes allowed
pop_cnt_i  in  clog2(ISSUE_W+1)  entries consumed this cycle
issue_inst_o  out  ISSUE_W*32  head entries, slot 0 = oldest
issue_pc_o  out  ISSUE_W*32  PCs of head entries
issue_valid_o  out  ISSUE_W  slot k valid iff count > k
count_o  out  clog2(DEPTH+1)  current occupancy
full_o  out  1  almost-full stall request to IF
overflow_o  out  1  sticky: bundle dropped for lack of space

Behaviour:
- Reset (rst low, async): head=tail=0, count_o=0, issue_valid_o=0, full_o=0, overflow_o=0, ds_wait=0. Storage is not cleared.
- Outputs are combinational from head pointer and storage (zero-latency peek). issue_inst_o/issue_pc_o are 0 for invalid slots.
- Pop: head advances by min(pop_cnt_i, count) at the clock edge. A pop_cnt_i > count is a protocol error (assertion) and is clipped.
- Push: valid slots are compacted in slot order and written at tail, tail..tail+n-1 mod DEPTH.
  - Accepted only if free space (DEPTH - count + popped this cycle) >= n. Otherwise the whole bundle is dropped and overflow_o is set until reset.
- Push and pop in the same cycle are both applied: count_next = count - popped + pushed.
- Pointer wrap: modulo DEPTH, natural binary overflow of clog2(DEPTH)-bit pointers.
- full_o = (DEPTH - count) < 2*FETCH_W, registered from count_next, giving one bundle of slack for the fetch in flight.
- stall_i=1: no push, no pop, state held. flush_i has priority over stall_i.
- flush_i=1, keep_ds_i=0: count=0, head=tail, ds_wait=0. That cycle's push and pop are ignored.
- flush_i=1, keep_ds_i=1: the entry at position (popped this cycle) behind head is the delay slot.
  - If it exists (count > popped), it becomes the sole entry (count=1).
  - Otherwise count=0, ds_wait=1.
  - While ds_wait=1, only the lowest valid slot of the next non-empty push bundle is stored; the rest are discarded. ds_wait then clears.
- Simultaneous flush and a new flush during ds_wait: the later flush re-evaluates with the rules above.

Optional Feature:
- Macro INSTQ_PERF_EN.
- When defined: adds outputs perf_full_cyc_o[31:0] (cycles with full_o=1), perf_empty_cyc_o[31:0] (cycles with count=0 and stall_i=0), and perf_drop_o[31:0] (dropped bundles).
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/defines:
  - entry width constant (INST_ENTRY_WD = 64)
  - entry layout {pc, inst}
  - pop-count width helper
  - IssueMode encodings shared with the decoder (SingleIssue/DualIssue)
- One natural sub-module: inst_issue_compact, a combinational FETCH_W-slot valid-compaction network producing the packed write vector and count n.

Test Plan (DEPTH=16, FETCH_W=2, ISSUE_W=2):
- Reset mid-operation with count=5 -> all outputs 0 immediately, before the next clock edge; next push of pc 0xBFC00000/0xBFC00004 appears at issue slots 0/1 one cycle later.
- 8 full bundles pushed, no pop -> count=16; full_o=1 once count>12; 9th bundle dropped, overflow_o=1, count stays 16.
- push_valid_i=2'b10 with pc 0x100/0x104 -> single entry pc 0x104 at slot 0; count=1.
- count=3, pop_cnt_i=2 and push 2 in the same cycle -> count=3; head shows the old third entry then the first new one.
- count=4, flush_i=1, keep_ds_i=1, pop_cnt_i=1 -> count=1 holding the old second entry. Same with count=1, pop=1 -> count=0; next push pcs 0x200/0x204 leaves only 0x200.
- Wrap: 20 push/pop cycles at steady count=2 -> PC order preserved across pointer wrap; no spurious issue_valid_o.
